// File: rtl/ratfl_checkpoint_ctrl.sv
// Branch checkpoint store beside rename: captures RAT/free-list snapshots per branch,
// frees them on correct resolution and replays them one cycle after a mispredict.
module ratfl_checkpoint_ctrl #(
  parameter int PREGS     = 64,
  parameter int PREG_W    = $clog2(PREGS),
  parameter int NUM_CHKPT = 4,
  parameter int TAG_W     = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    chkpt_we_i,
  input  logic [TAG_W-1:0]        chkpt_tag_i,
  input  logic [32*PREG_W-1:0]    chkpt_rat_map_i,
  input  logic [PREG_W-1:0]       chkpt_fl_head_i,
  input  logic [PREG_W-1:0]       chkpt_fl_tail_i,
  input  logic [$clog2(PREGS):0]  chkpt_fl_free_count_i,
  output logic                    chkpt_full_o,
  input  logic                    resolve_valid_i,
  input  logic [TAG_W-1:0]        resolve_tag_i,
  input  logic                    resolve_mispredict_i,
  output logic                    rat_recover_o,
  output logic [32*PREG_W-1:0]    rat_recover_map_o,
  output logic                    fl_recover_o,
  output logic [PREG_W-1:0]       fl_recover_head_o,
  output logic [PREG_W-1:0]       fl_recover_tail_o,
  output logic [$clog2(PREGS):0]  fl_recover_free_count_o,
  output logic [TAG_W-1:0]        flush_tag_o,
  output logic                    overflow_o
);
  localparam int IDX_W = $clog2(NUM_CHKPT);
  localparam int MAP_W = 32 * PREG_W;
  localparam int CNT_W = $clog2(PREGS) + 1;

  typedef enum logic [1:0] {SLOT_FREE, SLOT_PENDING, SLOT_RESOLVED} slot_state_t;

  slot_state_t        state_q   [NUM_CHKPT];
  logic [TAG_W-1:0]   tag_q     [NUM_CHKPT];
  logic [MAP_W-1:0]   map_q     [NUM_CHKPT];
  logic [PREG_W-1:0]  fl_head_q [NUM_CHKPT];
  logic [PREG_W-1:0]  fl_tail_q [NUM_CHKPT];
  logic [CNT_W-1:0]   fl_cnt_q  [NUM_CHKPT];

  logic [IDX_W-1:0] head_q, tail_q;
  logic [IDX_W:0]   count_q;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             accept, do_res, do_mis, do_ok, do_cap, do_ovf, reclaim;
  logic [IDX_W-1:0] mis_pos;
  logic [NUM_CHKPT-1:0] squash;

  // Distance from b to a around the ring; the power-of-2 size makes wrap free.
  function automatic logic [IDX_W-1:0] ring_dist(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    return a - b;
  endfunction

  assign chkpt_full_o = (count_q == (IDX_W+1)'(NUM_CHKPT));

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CHKPT - 1; i >= 0; i--) begin
      if (state_q[i] == SLOT_PENDING && tag_q[i] == resolve_tag_i) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Rename and backend are flushing during the recovery pulse, so their requests are dropped.
  assign accept  = !rat_recover_o;
  assign do_res  = accept && resolve_valid_i && hit;
  assign do_mis  = do_res && resolve_mispredict_i;
  assign do_ok   = do_res && !resolve_mispredict_i;
  assign do_cap  = accept && chkpt_we_i && !do_mis && !chkpt_full_o;
  assign do_ovf  = accept && chkpt_we_i && !do_mis && chkpt_full_o;
  assign reclaim = (state_q[head_q] == SLOT_RESOLVED) && !(do_mis && head_q == hit_idx);
  assign mis_pos = ring_dist(hit_idx, head_q);

  always_comb begin
    squash = '0;
    for (int i = 0; i < NUM_CHKPT; i++) begin
      squash[i] = do_mis
               && (ring_dist(IDX_W'(i), head_q) >= mis_pos)
               && ({1'b0, ring_dist(IDX_W'(i), head_q)} < count_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CHKPT; i++) state_q[i] <= SLOT_FREE;
      head_q                  <= '0;
      tail_q                  <= '0;
      count_q                 <= '0;
      overflow_o              <= 1'b0;
      rat_recover_o           <= 1'b0;
      fl_recover_o            <= 1'b0;
      rat_recover_map_o       <= '0;
      fl_recover_head_o       <= '0;
      fl_recover_tail_o       <= '0;
      fl_recover_free_count_o <= '0;
      flush_tag_o             <= '0;
    end else begin
      rat_recover_o           <= do_mis;
      fl_recover_o            <= do_mis;
      rat_recover_map_o       <= do_mis ? map_q[hit_idx]     : '0;
      fl_recover_head_o       <= do_mis ? fl_head_q[hit_idx] : '0;
      fl_recover_tail_o       <= do_mis ? fl_tail_q[hit_idx] : '0;
      fl_recover_free_count_o <= do_mis ? fl_cnt_q[hit_idx]  : '0;
      flush_tag_o             <= do_mis ? tag_q[hit_idx]     : '0;
      if (do_ovf) overflow_o <= 1'b1;

      for (int i = 0; i < NUM_CHKPT; i++) begin
        if (squash[i]) state_q[i] <= SLOT_FREE;
      end
      if (do_ok)  state_q[hit_idx] <= SLOT_RESOLVED;
      if (do_cap) state_q[tail_q]  <= SLOT_PENDING;
      if (reclaim) begin
        state_q[head_q] <= SLOT_FREE;
        head_q          <= head_q + 1'b1;
      end

      if (do_mis) begin
        tail_q  <= hit_idx;
        count_q <= {1'b0, mis_pos} - {{IDX_W{1'b0}}, reclaim};
      end else begin
        if (do_cap) tail_q <= tail_q + 1'b1;
        count_q <= count_q + {{IDX_W{1'b0}}, do_cap} - {{IDX_W{1'b0}}, reclaim};
      end
    end
  end

  // Snapshot payload needs no reset: it is only read through slots marked PENDING.
  always_ff @(posedge clk_i) begin
    if (do_cap) begin
      tag_q[tail_q]     <= chkpt_tag_i;
      map_q[tail_q]     <= chkpt_rat_map_i;
      fl_head_q[tail_q] <= chkpt_fl_head_i;
      fl_tail_q[tail_q] <= chkpt_fl_tail_i;
      fl_cnt_q[tail_q]  <= chkpt_fl_free_count_i;
    end
  end

endmodule

// File: tb/tb_ratfl_checkpoint_ctrl.sv
// Directed and random bench for ratfl_checkpoint_ctrl against a program-order queue model.
module tb_ratfl_checkpoint_ctrl;
  localparam int PREG_W = 6;
  localparam int TAG_W  = 4;
  localparam int MAP_W  = 32 * PREG_W;
  localparam int CNT_W  = 7;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               chkpt_we_i = 1'b0;
  logic [TAG_W-1:0]   chkpt_tag_i = '0;
  logic [MAP_W-1:0]   chkpt_rat_map_i = '0;
  logic [PREG_W-1:0]  chkpt_fl_head_i = '0;
  logic [PREG_W-1:0]  chkpt_fl_tail_i = '0;
  logic [CNT_W-1:0]   chkpt_fl_free_count_i = '0;
  logic               chkpt_full_o;
  logic               resolve_valid_i = 1'b0;
  logic [TAG_W-1:0]   resolve_tag_i = '0;
  logic               resolve_mispredict_i = 1'b0;
  logic               rat_recover_o;
  logic [MAP_W-1:0]   rat_recover_map_o;
  logic               fl_recover_o;
  logic [PREG_W-1:0]  fl_recover_head_o;
  logic [PREG_W-1:0]  fl_recover_tail_o;
  logic [CNT_W-1:0]   fl_recover_free_count_o;
  logic [TAG_W-1:0]   flush_tag_o;
  logic               overflow_o;

  ratfl_checkpoint_ctrl #(.PREGS(64), .PREG_W(PREG_W), .NUM_CHKPT(4), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .chkpt_we_i(chkpt_we_i), .chkpt_tag_i(chkpt_tag_i), .chkpt_rat_map_i(chkpt_rat_map_i),
    .chkpt_fl_head_i(chkpt_fl_head_i), .chkpt_fl_tail_i(chkpt_fl_tail_i),
    .chkpt_fl_free_count_i(chkpt_fl_free_count_i), .chkpt_full_o(chkpt_full_o),
    .resolve_valid_i(resolve_valid_i), .resolve_tag_i(resolve_tag_i),
    .resolve_mispredict_i(resolve_mispredict_i),
    .rat_recover_o(rat_recover_o), .rat_recover_map_o(rat_recover_map_o),
    .fl_recover_o(fl_recover_o), .fl_recover_head_o(fl_recover_head_o),
    .fl_recover_tail_o(fl_recover_tail_o), .fl_recover_free_count_o(fl_recover_free_count_o),
    .flush_tag_o(flush_tag_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    bit                resolved;
    logic [MAP_W-1:0]  map;
    logic [PREG_W-1:0] h;
    logic [PREG_W-1:0] t;
    logic [CNT_W-1:0]  c;
  } ent_t;

  ent_t mq[$];      // live checkpoints, oldest first
  bit   m_rec = 0;  // recovery pulse expected on the outputs right now
  bit   m_ovf = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    chkpt_we_i = 1'b0;
    resolve_valid_i = 1'b0;
    resolve_mispredict_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #2;
    chk("reset_full", 256'(chkpt_full_o), 256'(0));
    chk("reset_recover", 256'(rat_recover_o), 256'(0));
    chk("reset_overflow", 256'(overflow_o), 256'(0));
    chk("reset_map", 256'(rat_recover_map_o), 256'(0));
    mq.delete();
    m_rec = 0;
    m_ovf = 0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // One clock: drive inputs, advance the model, then compare every output after the edge.
  task automatic step(input bit we, input logic [TAG_W-1:0] ctag, input bit rv,
                      input logic [TAG_W-1:0] rtag, input bit mis);
    ent_t e, rec;
    int   p;
    bit   recl, exp_rec;
    chkpt_we_i = we;
    chkpt_tag_i = ctag;
    for (int k = 0; k < MAP_W / 32; k++) chkpt_rat_map_i[k*32 +: 32] = $urandom;
    chkpt_fl_head_i = PREG_W'($urandom);
    chkpt_fl_tail_i = PREG_W'($urandom);
    chkpt_fl_free_count_i = CNT_W'($urandom_range(0, 64));
    resolve_valid_i = rv;
    resolve_tag_i = rtag;
    resolve_mispredict_i = mis;

    recl = (mq.size() > 0) && mq[0].resolved;
    exp_rec = 0;
    rec = '{tag: '0, resolved: 0, map: '0, h: '0, t: '0, c: '0};
    if (!m_rec) begin
      p = -1;
      if (rv) foreach (mq[i]) if (p < 0 && !mq[i].resolved && mq[i].tag == rtag) p = i;
      if (p >= 0 && mis) begin
        exp_rec = 1;
        rec = mq[p];
        while (mq.size() > p) mq.delete(mq.size() - 1);
      end else begin
        if (p >= 0) mq[p].resolved = 1;
        if (we) begin
          if (mq.size() < 4) begin
            e = '{tag: ctag, resolved: 0, map: chkpt_rat_map_i, h: chkpt_fl_head_i,
                  t: chkpt_fl_tail_i, c: chkpt_fl_free_count_i};
            mq.push_back(e);
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
    if (recl) mq.delete(0);
    m_rec = exp_rec;

    @(posedge clk_i);
    #1;
    chk("rat_recover", 256'(rat_recover_o), 256'(exp_rec));
    chk("fl_recover", 256'(fl_recover_o), 256'(exp_rec));
    chk("recover_map", 256'(rat_recover_map_o), 256'(rec.map));
    chk("recover_head", 256'(fl_recover_head_o), 256'(rec.h));
    chk("recover_tail", 256'(fl_recover_tail_o), 256'(rec.t));
    chk("recover_count", 256'(fl_recover_free_count_o), 256'(rec.c));
    chk("flush_tag", 256'(flush_tag_o), 256'(rec.tag));
    chk("full", 256'(chkpt_full_o), 256'(mq.size() == 4));
    chk("overflow", 256'(overflow_o), 256'(m_ovf));
  endtask

  function automatic logic [TAG_W-1:0] fresh_tag();
    logic [TAG_W-1:0] t;
    bit used;
    t = '0;
    for (int a = 0; a < 64; a++) begin
      t = TAG_W'($urandom_range(0, 15));
      used = 0;
      foreach (mq[i]) if (mq[i].tag == t) used = 1;
      if (!used) return t;
    end
    return t;
  endfunction

  initial begin
    logic [TAG_W-1:0] pend[$];
    logic [TAG_W-1:0] rtag;
    bit we, rv;

    // T1: four captures fill the store, one correct resolve frees a slot
    do_reset();
    for (int k = 1; k <= 4; k++) step(1, TAG_W'(k), 0, 0, 0);
    chk("t1_full", 256'(chkpt_full_o), 256'(1));
    step(0, 0, 1, 4'd1, 0);
    step(0, 0, 0, 0, 0);
    chk("t1_not_full", 256'(chkpt_full_o), 256'(0));

    // T2: out-of-order resolves; head waits for tag 2, then reclaims 2 and 3
    step(0, 0, 1, 4'd3, 0);
    step(0, 0, 1, 4'd2, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int k = 10; k <= 12; k++) step(1, TAG_W'(k), 0, 0, 0);
    chk("t2_refill_full", 256'(chkpt_full_o), 256'(1));

    // T3: mispredict the middle of three checkpoints
    do_reset();
    for (int k = 5; k <= 7; k++) step(1, TAG_W'(k), 0, 0, 0);
    step(0, 0, 1, 4'd6, 1);
    chk("t3_pulse", 256'(rat_recover_o), 256'(1));
    chk("t3_flush_tag", 256'(flush_tag_o), 256'(6));
    step(0, 0, 0, 0, 0);
    chk("t3_pulse_end", 256'(rat_recover_o), 256'(0));
    for (int k = 1; k <= 3; k++) step(1, TAG_W'(k), 0, 0, 0);
    chk("t3_count_one_then_full", 256'(chkpt_full_o), 256'(1));

    // T4: capture of tag 9 in the same cycle as mispredict of tag 8 is squashed
    do_reset();
    step(1, 4'd8, 0, 0, 0);
    step(1, 4'd9, 1, 4'd8, 1);
    chk("t4_flush_tag", 256'(flush_tag_o), 256'(8));
    chk("t4_no_overflow", 256'(overflow_o), 256'(0));
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 4'd9, 1);
    chk("t4_tag9_absent", 256'(rat_recover_o), 256'(0));

    // T5: overflow, drain, then wrap the pointers
    do_reset();
    for (int k = 1; k <= 6; k++) step(1, TAG_W'(k), 0, 0, 0);
    chk("t5_overflow", 256'(overflow_o), 256'(1));
    for (int k = 1; k <= 4; k++) step(0, 0, 1, TAG_W'(k), 0);
    step(0, 0, 0, 0, 0);
    chk("t5_drained", 256'(chkpt_full_o), 256'(0));
    for (int k = 7; k <= 10; k++) step(1, TAG_W'(k), 0, 0, 0);
    chk("t5_wrap_full", 256'(chkpt_full_o), 256'(1));
    step(0, 0, 1, 4'd9, 1);
    chk("t5_wrap_flush", 256'(flush_tag_o), 256'(9));
    step(0, 0, 0, 0, 0);

    // T6: reset during the recovery pulse cancels it at once
    do_reset();
    for (int k = 1; k <= 5; k++) step(1, TAG_W'(k), 0, 0, 0);
    step(0, 0, 1, 4'd2, 1);
    chk("t6_pulse", 256'(rat_recover_o), 256'(1));
    rst_ni = 1'b0;
    #1;
    chk("t6_recover_cancel", 256'(rat_recover_o), 256'(0));
    chk("t6_fl_cancel", 256'(fl_recover_o), 256'(0));
    chk("t6_full", 256'(chkpt_full_o), 256'(0));
    chk("t6_overflow", 256'(overflow_o), 256'(0));
    chk("t6_flush_tag", 256'(flush_tag_o), 256'(0));
    mq.delete();
    m_rec = 0;
    m_ovf = 0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Random traffic against the queue model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      pend.delete();
      foreach (mq[i]) if (!mq[i].resolved) pend.push_back(mq[i].tag);
      we = ($urandom_range(0, 1) == 1);
      rv = ($urandom_range(0, 1) == 1);
      if (pend.size() > 0 && $urandom_range(0, 4) != 0)
        rtag = pend[$urandom_range(0, pend.size() - 1)];
      else
        rtag = TAG_W'($urandom_range(0, 15));
      step(we, fresh_tag(), rv, rtag, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
